// File: rtl/rs_alu_issue_sched.sv
// Oldest-ready-first issue scheduler for the ALU reservation station.
// Age matrix ordering, combinational winner selection, registered valid/ready offer to the ALU.
module rs_alu_issue_sched #(
   parameter int RS_ENTRY_NUM = 2,
   parameter int IDX_WIDTH    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    alloc_valid,
   input  logic [IDX_WIDTH-1:0]    alloc_idx,
   input  logic [RS_ENTRY_NUM-1:0] entry_ready,
   input  logic                    flush,
   output logic                    issue_valid,
   output logic [IDX_WIDTH-1:0]    issue_idx,
   output logic [RS_ENTRY_NUM-1:0] issue_onehot,
   input  logic                    fu_ready,
   output logic                    issue_fire
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] OFFER = 1'b1;

   logic [0:0]                                state;
   logic [RS_ENTRY_NUM-1:0][RS_ENTRY_NUM-1:0] older;
   logic [RS_ENTRY_NUM-1:0]                   cand;
   logic [RS_ENTRY_NUM-1:0]                   win;
   logic [RS_ENTRY_NUM-1:0]                   sel_onehot;
   logic [IDX_WIDTH-1:0]                      sel_idx;
   logic                                      found;

   assign issue_valid = (state == OFFER);
   assign issue_fire  = issue_valid && fu_ready && !flush;

   // issue_onehot is zero when idle, so it masks both a held offer and an entry
   // whose Busy bit is still visible in the cycle it fires.
   assign cand = entry_ready & ~issue_onehot;

   always_comb begin
      win = cand;
      for (int i = 0; i < RS_ENTRY_NUM; i++) begin
         for (int j = 0; j < RS_ENTRY_NUM; j++) begin
            if (i != j && cand[j] && older[j][i]) win[i] = 1'b0;
         end
      end
   end

   // Several winners only occur while ages are unset; lowest index breaks the tie.
   always_comb begin
      sel_idx    = '0;
      sel_onehot = '0;
      found      = 1'b0;
      for (int i = 0; i < RS_ENTRY_NUM; i++) begin
         if (win[i] && !found) begin
            found         = 1'b1;
            sel_idx       = IDX_WIDTH'(i);
            sel_onehot[i] = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         issue_idx    <= '0;
         issue_onehot <= '0;
      end else if (flush) begin
         state        <= IDLE;
         issue_onehot <= '0;
      end else if (!issue_valid || issue_fire) begin
         if (found) begin
            state        <= OFFER;
            issue_idx    <= sel_idx;
            issue_onehot <= sel_onehot;
         end else begin
            state        <= IDLE;
            issue_onehot <= '0;
         end
      end
   end

   // Allocated entry becomes youngest: its row clears, its column sets.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         older <= '0;
      end else if (flush) begin
         older <= '0;
      end else if (alloc_valid) begin
         for (int j = 0; j < RS_ENTRY_NUM; j++) begin
            older[alloc_idx][j] <= 1'b0;
            if (IDX_WIDTH'(j) != alloc_idx) older[j][alloc_idx] <= 1'b1;
         end
      end
   end

endmodule
